// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response bundle between the execute stage and muldiv_unit.
//
//   master (core side) drives : start, op, rs1, rs2, kill
//   slave  (unit side) drives : ready, busy, done, result
//
//   Parameter XLEN must match the XLEN of the attached muldiv_unit.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, kill,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, kill,
        output ready, busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RISC-V M-extension multiply/divide unit.
//     MUL*  : radix-2^MUL_BITS shift-add on operand magnitudes, XLEN/MUL_BITS
//             iterations.
//     DIV*  : restoring radix-2 division, XLEN iterations.
//   Signs are stripped at accept and re-applied in a single FIX cycle.
//   Divide-by-zero and signed overflow bypass iteration entirely.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : muldiv_unit_if.slave (start/op/rs1/rs2/kill in,
//            ready/busy/done/result out)
//
//   Compile-time option:
//     MULDIV_EARLY_OUT_EN : when defined, the multiply loop stops as soon as
//                           the remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int K_MUL = XLEN / MUL_BITS;
    localparam int CW    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q;     // product, or {remainder, quotient}
    logic [2*XLEN-1:0] mcand_q;   // multiplicand, pre-shifted into place
    logic [XLEN-1:0]   mplier_q;  // multiplier digits left, or divisor
    logic [CW-1:0]     cnt_q;
    logic              neg_pq_q;  // negate product / quotient
    logic              neg_r_q;   // negate remainder
    logic [XLEN-1:0]   result_q;

    // ---------------- accept-time decode ----------------
    logic            accept, is_div, sgn1, sgn2, s1, s2, div0, ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        accept = (state_q == S_IDLE) && bus.start && !bus.kill;
        is_div = bus.op[2];
        // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM
        sgn1   = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
        sgn2   = is_div ? !bus.op[0] : !bus.op[1];
        s1     = sgn1 && bus.rs1[XLEN-1];
        s2     = sgn2 && bus.rs2[XLEN-1];
        mag1   = s1 ? -bus.rs1 : bus.rs1;
        mag2   = s2 ? -bus.rs2 : bus.rs2;
        div0   = is_div && (bus.rs2 == '0);
        ovf    = is_div && !bus.op[0] && (bus.rs1 == MOST_NEG) && (bus.rs2 == '1);
        special = div0 || ovf;
        // op[1] separates REM* from DIV*
        if (div0) special_res = bus.op[1] ? bus.rs1 : '1;
        else      special_res = bus.op[1] ? '0 : bus.rs1;
    end

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] pp_sum, mul_acc_nx, div_acc_nx, prod_fix;
    logic [XLEN:0]     div_upper;
    logic [XLEN-1:0]   rem_sub, quo_fix, rem_fix, fix_res;
    logic              div_ge, mul_last;

    always_comb begin
        pp_sum = '0;
        for (int j = 0; j < MUL_BITS; j++)
            if (mplier_q[j]) pp_sum = pp_sum + (mcand_q << j);
        mul_acc_nx = acc_q + pp_sum;

`ifdef MULDIV_EARLY_OUT_EN
        mul_last = (cnt_q == CW'(1)) || ((mplier_q >> MUL_BITS) == '0);
`else
        mul_last = (cnt_q == CW'(1));
`endif

        // Restoring step: shift {R,Q} left by one, trial-subtract divisor.
        // The true difference is below the divisor, so XLEN bits hold it.
        div_upper  = acc_q[2*XLEN-1:XLEN-1];
        div_ge     = div_upper >= {1'b0, mplier_q};
        rem_sub    = div_upper[XLEN-1:0] - mplier_q;
        div_acc_nx = div_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                            : {acc_q[2*XLEN-2:0], 1'b0};

        prod_fix = neg_pq_q ? -acc_q : acc_q;
        quo_fix  = neg_pq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_r_q  ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_OUT : (is_div ? S_DIV : S_MUL);
            S_MUL:  if (mul_last) state_d = S_FIX;
            S_DIV:  if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_OUT;
            S_OUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.ready  = (state_q == S_IDLE);
        bus.busy   = (state_q != S_IDLE);
        bus.done   = (state_q == S_OUT);
        bus.result = result_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q     <= bus.op;
                    acc_q    <= is_div ? {{XLEN{1'b0}}, mag1} : '0;
                    mcand_q  <= {{XLEN{1'b0}}, mag1};
                    mplier_q <= mag2;
                    cnt_q    <= is_div ? CW'(XLEN) : CW'(K_MUL);
                    neg_pq_q <= s1 ^ s2;
                    neg_r_q  <= s1;
                    if (special) result_q <= special_res;
                end
                S_MUL: begin
                    acc_q    <= mul_acc_nx;
                    mcand_q  <= mcand_q << MUL_BITS;
                    mplier_q <= mplier_q >> MUL_BITS;
                    cnt_q    <= cnt_q - CW'(1);
                end
                S_DIV: begin
                    acc_q <= div_acc_nx;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: if (!bus.kill) result_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule
